// File: rtl/pkg_ili9341.sv
// Shared types and constants for the ILI9341 SPI link models.
package pkg_ili9341;

  typedef enum logic [1:0] {
    IDLE,
    RX,
    TX_ID
  } st_spi_slv_state_e;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } st_rx_entry;

  localparam logic [7:0] RDDID = 8'h04;

endpackage

// File: rtl/spi_rx_fifo.sv
// Show-ahead receive FIFO with wrap-bit pointers and a sticky overflow flag.
module spi_rx_fifo
  import pkg_ili9341::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  st_rx_entry wdata_i,
  input  logic       pop_i,
  input  logic       clr_ovf_i,
  output st_rx_entry rdata_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       overflow_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  logic        do_push, do_pop, drop;
  st_rx_entry  mem_q [Depth];

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o    = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_o = ovf_q;

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    do_push  = push_i & (~full_o | do_pop);
    drop     = push_i & full_o & ~do_pop;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    ovf_d    = (ovf_q & ~clr_ovf_i) | drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ili_spi_slave.sv
// ILI9341-side SPI responder: oversampled receive into a FIFO, ID read-back on MISO.
module ili_spi_slave
  import pkg_ili9341::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  ID_CMD     = RDDID
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sclk,
  input  logic        i_mosi,
  input  logic        i_dc,
  input  logic        i_cs,
  input  logic [23:0] i_id_data,
  input  logic        i_rd_en,
  input  logic        i_clr_ovf,
  output logic        o_miso,
  output logic        o_miso_oe,
  output logic [8:0]  o_rd_data,
  output logic        o_empty,
  output logic        o_full,
  output logic        o_overflow,
  output logic        o_frame_err
);

  logic [2:0] sclk_sync_q, cs_sync_q;
  logic [1:0] mosi_sync_q, dc_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      dc_sync_q   <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], i_sclk};
      cs_sync_q   <= {cs_sync_q[1:0], i_cs};
      mosi_sync_q <= {mosi_sync_q[0], i_mosi};
      dc_sync_q   <= {dc_sync_q[0], i_dc};
    end
  end

  logic cs_lo, cs_rise, rise, fall, mosi_s, dc_s;
  assign cs_lo   = ~cs_sync_q[1];
  assign cs_rise = cs_sync_q[1] & ~cs_sync_q[2];
  assign rise    = cs_lo & sclk_sync_q[1] & ~sclk_sync_q[2];
  assign fall    = cs_lo & ~sclk_sync_q[1] & sclk_sync_q[2];
  assign mosi_s  = mosi_sync_q[1];
  assign dc_s    = dc_sync_q[1];

  st_spi_slv_state_e state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [4:0]  tx_cnt_q, tx_cnt_d;
  logic [23:0] id_q, id_d;
  logic        miso_q, miso_d, miso_oe_q, miso_oe_d, frame_err_q, frame_err_d;
  logic        push, rx_en;
  st_rx_entry  push_entry;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_cnt_d    = tx_cnt_q;
    id_d        = id_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    push_entry  = '{dc: dc_s, data: {shift_q, mosi_s}};
    // An edge arriving in the same cycle CS is first seen low is still captured.
    rx_en       = (state_q == RX) || (state_q == IDLE && cs_lo);

    if (cs_rise) begin
      state_d     = IDLE;
      bit_cnt_d   = 3'd0;
      tx_cnt_d    = 5'd0;
      miso_d      = 1'b0;
      miso_oe_d   = 1'b0;
      frame_err_d = (state_q == RX) && (bit_cnt_q != 3'd0);
    end else begin
      if (state_q == IDLE && cs_lo) state_d = RX;
      if (rx_en && rise) begin
        shift_d   = {shift_q[5:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          push = 1'b1;
          if (!dc_s && {shift_q, mosi_s} == ID_CMD) begin
            state_d   = TX_ID;
            id_d      = i_id_data;
            miso_d    = i_id_data[23];
            miso_oe_d = 1'b1;
            tx_cnt_d  = 5'd0;
          end
        end
      end
      if (state_q == TX_ID) begin
        if (rise) begin
          tx_cnt_d = tx_cnt_q + 5'd1;
          if (tx_cnt_q == 5'd23) begin
            state_d   = RX;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
          end
        // The fall closing the command byte must not consume ID bit 23.
        end else if (fall && tx_cnt_q != 5'd0) begin
          id_d   = {id_q[22:0], 1'b0};
          miso_d = id_q[22];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      tx_cnt_q    <= 5'd0;
      id_q        <= 24'd0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_cnt_q    <= tx_cnt_d;
      id_q        <= id_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_miso      = miso_q;
  assign o_miso_oe   = miso_oe_q;
  assign o_frame_err = frame_err_q;

  st_rx_entry rd_entry;
  assign o_rd_data = rd_entry;

  spi_rx_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wdata_i   (push_entry),
    .pop_i     (i_rd_en),
    .clr_ovf_i (i_clr_ovf),
    .rdata_o   (rd_entry),
    .empty_o   (o_empty),
    .full_o    (o_full),
    .overflow_o(o_overflow)
  );

endmodule

// File: tb/tb_ili_spi_slave.sv
// Scoreboard bench for ili_spi_slave: queue model of the receive FIFO, MISO checked per bit.
module tb_ili_spi_slave;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_sclk, i_mosi, i_dc, i_cs;
  logic [23:0] i_id_data;
  logic        i_rd_en, i_clr_ovf;
  logic        o_miso, o_miso_oe, o_empty, o_full, o_overflow, o_frame_err;
  logic [8:0]  o_rd_data;

  ili_spi_slave #(
    .FIFO_DEPTH(DEPTH),
    .ID_CMD    (8'h04)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_sclk     (i_sclk),
    .i_mosi     (i_mosi),
    .i_dc       (i_dc),
    .i_cs       (i_cs),
    .i_id_data  (i_id_data),
    .i_rd_en    (i_rd_en),
    .i_clr_ovf  (i_clr_ovf),
    .o_miso     (o_miso),
    .o_miso_oe  (o_miso_oe),
    .o_rd_data  (o_rd_data),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_overflow (o_overflow),
    .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];
  bit         auto_pop = 1'b0;
  bit         pop_once = 1'b0;
  bit         model_ovf = 1'b0;
  int         ferr_cnt = 0;
  int         exp_ferr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops whenever allowed and the DUT shows data, compares against the model.
  initial begin
    logic [8:0] exp_v;
    i_rd_en = 1'b0;
    forever begin
      @(negedge clk);
      if (o_frame_err === 1'b1) ferr_cnt++;
      if ((auto_pop || pop_once) && rst && o_empty === 1'b0) begin
        pop_once = 1'b0;
        i_rd_en  = 1'b1;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_data: got %0h expected no entry", o_rd_data);
        end else begin
          exp_v = exp_q.pop_front();
          n_checks--;
          check("rd_data", 32'(o_rd_data), 32'(exp_v));
        end
      end else begin
        i_rd_en = 1'b0;
      end
    end
  end

  task automatic model_push(input logic [8:0] e);
    if (exp_q.size() >= DEPTH) model_ovf = 1'b1;
    else exp_q.push_back(e);
  endtask

  task automatic spi_bit(input logic b, input logic d);
    @(negedge clk);
    i_mosi = b;
    i_dc   = d;
    repeat (3) @(negedge clk);
    i_sclk = 1'b1;
    repeat (4) @(negedge clk);
    i_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] data, input logic d, input bit pop_last);
    for (int i = 7; i >= 1; i--) spi_bit(data[i], d);
    @(negedge clk);
    i_mosi = data[0];
    i_dc   = d;
    repeat (3) @(negedge clk);
    i_sclk = 1'b1;
    @(negedge clk);
    if (pop_last) begin
      #1 pop_once = 1'b1;
    end
    @(negedge clk);
    #2 model_push({d, data});
    repeat (2) @(negedge clk);
    i_sclk = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    i_cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    i_cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, 32'(o_empty), 32'd1);
    check({tag, "_full"}, 32'(o_full), 32'd0);
    check({tag, "_ovf"}, 32'(o_overflow), 32'd0);
    check({tag, "_ferr"}, 32'(o_frame_err), 32'd0);
    check({tag, "_miso"}, 32'(o_miso), 32'd0);
    check({tag, "_oe"}, 32'(o_miso_oe), 32'd0);
  endtask

  task automatic drain(input string tag);
    auto_pop = 1'b1;
    repeat (40) @(negedge clk);
    check({tag, "_empty"}, 32'(o_empty), 32'd1);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [7:0] safe_byte(input logic [7:0] b, input logic d);
    return (!d && b == 8'h04) ? 8'h05 : b;
  endfunction

  initial begin
    logic [7:0]  b;
    logic        d;
    logic [23:0] id;
    rst = 1'b0;
    i_sclk = 1'b0; i_mosi = 1'b0; i_dc = 1'b0; i_cs = 1'b1;
    i_id_data = 24'd0; i_clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset in the middle of a byte, then a clean byte.
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    i_cs = 1'b1;
    exp_q.delete();
    model_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b1;
    repeat (4) @(negedge clk);
    auto_pop = 1'b1;
    cs_low();
    spi_byte(8'h11, 1'b0, 1'b0);
    cs_high();
    drain("rst_byte");

    // Command then data with CS held low.
    cs_low();
    spi_byte(8'h36, 1'b0, 1'b0);
    spi_byte(8'h48, 1'b1, 1'b0);
    cs_high();
    drain("cmd_data");

    // Random bytes and D/C flags.
    cs_low();
    for (int i = 0; i < 6; i++) begin
      d = 1'($urandom_range(0, 1));
      b = safe_byte(8'($urandom), d);
      spi_byte(b, d, 1'b0);
    end
    cs_high();
    drain("random");

    // ID read-back.
    for (int k = 0; k < 2; k++) begin
      id = (k == 0) ? 24'h009341 : 24'($urandom);
      i_id_data = id;
      cs_low();
      spi_byte(8'h04, 1'b0, 1'b0);
      i_id_data = ~id;
      for (int i = 23; i >= 0; i--) begin
        @(negedge clk);
        i_mosi = 1'($urandom_range(0, 1));
        repeat (3) @(negedge clk);
        i_sclk = 1'b1;
        check("miso_bit", 32'(o_miso), 32'(id[i]));
        check("miso_oe_on", 32'(o_miso_oe), 32'd1);
        repeat (4) @(negedge clk);
        i_sclk = 1'b0;
      end
      check("miso_oe_off", 32'(o_miso_oe), 32'd0);
      check("miso_off", 32'(o_miso), 32'd0);
      cs_high();
      drain("id_fifo");
    end

    // Partial frame.
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(1'($urandom_range(0, 1)), 1'b1);
    cs_high();
    exp_ferr++;
    check("frame_err_cycles", 32'(ferr_cnt), 32'(exp_ferr));
    check("partial_empty", 32'(o_empty), 32'd1);
    cs_low();
    spi_byte(8'hAA, 1'b1, 1'b0);
    cs_high();
    drain("after_partial");

    // Overflow: nine bytes with no pops.
    auto_pop = 1'b0;
    repeat (2) @(negedge clk);
    cs_low();
    for (int i = 0; i < 9; i++) begin
      d = 1'($urandom_range(0, 1));
      spi_byte(safe_byte(8'($urandom), d), d, 1'b0);
    end
    repeat (4) @(negedge clk);
    check("ovf_full", 32'(o_full), 32'(exp_q.size() == DEPTH));
    check("ovf_flag", 32'(o_overflow), 32'(model_ovf));
    @(negedge clk);
    i_clr_ovf = 1'b1;
    @(negedge clk);
    i_clr_ovf = 1'b0;
    model_ovf = 1'b0;
    check("ovf_clear", 32'(o_overflow), 32'(model_ovf));

    // Push into a full FIFO with a same-cycle pop.
    d = 1'($urandom_range(0, 1));
    spi_byte(safe_byte(8'($urandom), d), d, 1'b1);
    repeat (4) @(negedge clk);
    check("pushpop_ovf", 32'(o_overflow), 32'(model_ovf));
    check("pushpop_full", 32'(o_full), 32'(exp_q.size() == DEPTH));
    cs_high();
    drain("pushpop_drain");

    check("frame_err_total", 32'(ferr_cnt), 32'(exp_ferr));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
